hamming_stream_encoder: RTL and testbench
=========================================

Name: hamming_stream_encoder

Overview:
- Parametrised systematic Hamming encoder with valid/ready streaming handshake, a registered pipeline of 1 or 2 stages, and an optional SECDED overall-parity bit.
- Supports shortened codes: the data width may be less than the full code dimension 2^M-1-M.
- Sits between the source/packetiser and the channel/modulator stage. Generalises the fixed (7,4) combinational encoder to any (2^M-1) code with backpressure and a word counter.

Parameters:
- M, 3, number of Hamming parity bits (3..6).
- K, 4, data bits per word; must satisfy 1 <= K <= 2^M-1-M (elaboration error otherwise).
- SECDED, 1, 1 = append overall parity bit; 0 = plain Hamming.
- PIPE_STAGES, 1, register stages between input and output (1 or 2).
- CNT_W, 16, width of the encoded-word counter.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  K  data word.
- i_dv  in  1  input valid.
- o_ready  out  1  encoder can accept i_data this cycle.
- o_data  out  N  codeword, where N = K+M+SECDED.
- o_dv  out  1  output valid.
- i_ready  in  1  downstream accepts o_data this cycle.
- i_cnt_clr  in  1  synchronous clear of o_count.
- o_count  out  CNT_W  number of codewords accepted downstream (mod 2^CNT_W).

Behaviour:
- Code construction:
  - Hamming positions are 1..2^M-1.
  - Data bit d[i] occupies the i-th non-power-of-two position, in increasing order (3,5,6,7,9,...).
  - Unused positions in a shortened code are zero.
  - Parity p[j] (j=0..M-1) = XOR of all data bits whose position has bit j set.
  - Example, M=3: p0=d0^d1^d3, p1=d0^d2^d3, p2=d1^d2^d3.
- Output layout:
  - o_data[K-1:0] = data.
  - o_data[K+M-1:K] = p[M-1:0].
  - If SECDED, o_data[N-1] = XOR of all other K+M bits (even overall parity).
- Handshake:
  - Input transfer occurs when i_dv && o_ready; output transfer occurs when o_dv && i_ready.
  - i_dv is never required to wait for o_ready; data is held by the source until accepted.
- Pipeline:
  - Each stage is a valid-bit + data register.
  - A stage loads when it is empty or its contents transfer out this cycle (ready_k = !valid_k || ready_{k+1}).
  - o_ready = ready of stage 1.
  - Full throughput (one word/cycle) under continuous i_ready=1.
- Stage function split:
  - PIPE_STAGES=1: the stage registers the full codeword.
  - PIPE_STAGES=2: stage 1 registers data + Hamming parity; stage 2 adds the SECDED bit and registers.
- Latency = PIPE_STAGES cycles from input transfer to o_dv, with i_ready held high.
- o_data and o_dv are direct register outputs (no combinational path from i_data). o_ready may depend combinationally on i_ready.
- Stalls:
  - With i_ready=0, o_data and o_dv hold stable.
  - The pipeline fills to PIPE_STAGES words, then o_ready=0.
  - No word is dropped or duplicated.
- Counter:
  - o_count increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.
  - If i_cnt_clr coincides with a transfer, o_count becomes 0 (clear wins).
- Reset:
  - Asserting i_rst_n=0 at any time (including mid-stream) immediately clears all stage valids, o_dv=0, o_data=0, o_count=0.
  - o_ready=1 from the first clock after reset release.
  - In-flight words are discarded.
- Bubble: when a stage is empty and nothing loads, its data register holds its old value; o_data is don't-care while o_dv=0.

Test Plan:
- M=3, K=4, SECDED=1, PIPE_STAGES=1, i_ready=1:
  - Send 4'b1011 -> o_data=8'h1B one cycle later, o_dv=1.
  - Send 4'b0001 -> 8'hB1.
  - Send 4'b1111 -> 8'hFF.
  - Send 4'b0000 -> 8'h00.
- Same config, SECDED=0: 4'b1011 -> 7'h1B; 4'b0001 -> 7'h31.
- Exhaustive/random, M=4 K=11 and shortened M=4 K=8:
  - Every output syndrome (XOR of positions of set bits) = 0.
  - If SECDED, overall parity is even.
  - The data field equals the input.
- Backpressure, PIPE_STAGES=2: stream 0..9 with i_ready toggling in pattern 1,0,0,1,...
  - Outputs arrive in order 0..9, none lost or duplicated.
  - o_ready drops after 2 stalled words.
  - o_data stable while o_dv && !i_ready.
  - o_count = 10.
- Counter: CNT_W=4; 17 transfers -> o_count=1. Assert i_cnt_clr on a transfer cycle -> o_count=0 next cycle.
- Reset mid-stream: assert i_rst_n=0 with 2 words in flight -> o_dv=0 and o_count=0 immediately (asynchronously). After release, the next input appears after PIPE_STAGES cycles with the correct codeword.

Source files
------------

// File: rtl/hamming_stream_encoder.sv
// Systematic (2^M-1) Hamming stream encoder with optional SECDED bit, shortened-code
// support, valid/ready pipeline of 1 or 2 register stages and an output word counter.
module hamming_stream_encoder #(
  parameter int M           = 3,
  parameter int K           = 4,
  parameter int SECDED      = 1,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [K-1:0]            i_data,
  input  logic                    i_dv,
  output logic                    o_ready,
  output logic [K+M+SECDED-1:0]   o_data,
  output logic                    o_dv,
  input  logic                    i_ready,
  input  logic                    i_cnt_clr,
  output logic [CNT_W-1:0]        o_count
);

  localparam int HW = K + M;
  localparam int N  = K + M + SECDED;

  if (M < 3 || M > 6 || K < 1 || K > (2 ** M) - 1 - M ||
      (SECDED != 0 && SECDED != 1) || (PIPE_STAGES != 1 && PIPE_STAGES != 2)) begin : g_param_err
    $error("hamming_stream_encoder: illegal parameter combination");
  end

  // Codeword position of data bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [K-1:0] parity_mask(input int j);
    logic [K-1:0] m;
    m = '0;
    for (int i = 0; i < K; i++) begin
      m[i] = ((data_pos(i) >> j) & 1) != 0;
    end
    return m;
  endfunction

  function automatic logic [N-1:0] add_overall(input logic [HW-1:0] w);
    logic [N-1:0] c;
    c = '0;
    c[HW-1:0] = w;
    if (SECDED == 1) c[N-1] = ^w;
    return c;
  endfunction

  logic [M-1:0]  par;
  logic [HW-1:0] ham_word;

  for (genvar gi = 0; gi < M; gi++) begin : g_par
    localparam logic [K-1:0] MASK = parity_mask(gi);
    assign par[gi] = ^(i_data & MASK);
  end

  assign ham_word = {par, i_data};

  if (PIPE_STAGES == 1) begin : g_p1
    logic         s1_vld_q, s1_vld_d;
    logic [N-1:0] s1_dat_q, s1_dat_d;
    logic         s1_rdy;

    assign s1_rdy = !s1_vld_q || i_ready;

    always_comb begin
      s1_vld_d = s1_vld_q;
      s1_dat_d = s1_dat_q;
      if (s1_rdy) begin
        s1_vld_d = i_dv;
        if (i_dv) s1_dat_d = add_overall(ham_word);
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1_vld_q <= 1'b0;
        s1_dat_q <= '0;
      end else begin
        s1_vld_q <= s1_vld_d;
        s1_dat_q <= s1_dat_d;
      end
    end

    assign o_ready = s1_rdy;
    assign o_dv    = s1_vld_q;
    assign o_data  = s1_dat_q;
  end else begin : g_p2
    // Stage 1 holds data + Hamming parity; stage 2 appends the overall parity bit.
    logic          s1_vld_q, s1_vld_d;
    logic [HW-1:0] s1_dat_q, s1_dat_d;
    logic          s2_vld_q, s2_vld_d;
    logic [N-1:0]  s2_dat_q, s2_dat_d;
    logic          s1_rdy, s2_rdy;

    assign s2_rdy = !s2_vld_q || i_ready;
    assign s1_rdy = !s1_vld_q || s2_rdy;

    always_comb begin
      s1_vld_d = s1_vld_q;
      s1_dat_d = s1_dat_q;
      s2_vld_d = s2_vld_q;
      s2_dat_d = s2_dat_q;
      if (s1_rdy) begin
        s1_vld_d = i_dv;
        if (i_dv) s1_dat_d = ham_word;
      end
      if (s2_rdy) begin
        s2_vld_d = s1_vld_q;
        if (s1_vld_q) s2_dat_d = add_overall(s1_dat_q);
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1_vld_q <= 1'b0;
        s1_dat_q <= '0;
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s1_vld_q <= s1_vld_d;
        s1_dat_q <= s1_dat_d;
        s2_vld_q <= s2_vld_d;
        s2_dat_q <= s2_dat_d;
      end
    end

    assign o_ready = s1_rdy;
    assign o_dv    = s2_vld_q;
    assign o_data  = s2_dat_q;
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear takes priority over a coincident output transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr)           cnt_d = '0;
    else if (o_dv && i_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_count = cnt_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Bench for hamming_stream_encoder: four configurations driven side by side and
// checked against a queue-based behavioural model of the code and handshake.
module tb_hamming_stream_encoder;

  localparam int PM[4]  = '{3, 3, 4, 4};
  localparam int PK[4]  = '{4, 4, 11, 8};
  localparam int PS[4]  = '{1, 0, 1, 0};
  localparam int PP[4]  = '{1, 1, 2, 2};
  localparam int PCW[4] = '{4, 16, 16, 16};

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        rst_n;
  logic [15:0] din[4];
  logic        dv_in[4];
  logic        rdy_in[4];
  logic        clr_in[4];

  logic [7:0]  a_od;  logic a_dv, a_rdy; logic [3:0]  a_cnt;
  logic [6:0]  b_od;  logic b_dv, b_rdy; logic [15:0] b_cnt;
  logic [15:0] c_od;  logic c_dv, c_rdy; logic [15:0] c_cnt;
  logic [11:0] d_od;  logic d_dv, d_rdy; logic [15:0] d_cnt;

  hamming_stream_encoder #(.M(3), .K(4), .SECDED(1), .PIPE_STAGES(1), .CNT_W(4)) u_a (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_data(din[0][3:0]), .i_dv(dv_in[0]), .o_ready(a_rdy),
    .o_data(a_od), .o_dv(a_dv), .i_ready(rdy_in[0]), .i_cnt_clr(clr_in[0]), .o_count(a_cnt));
  hamming_stream_encoder #(.M(3), .K(4), .SECDED(0), .PIPE_STAGES(1), .CNT_W(16)) u_b (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_data(din[1][3:0]), .i_dv(dv_in[1]), .o_ready(b_rdy),
    .o_data(b_od), .o_dv(b_dv), .i_ready(rdy_in[1]), .i_cnt_clr(clr_in[1]), .o_count(b_cnt));
  hamming_stream_encoder #(.M(4), .K(11), .SECDED(1), .PIPE_STAGES(2), .CNT_W(16)) u_c (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_data(din[2][10:0]), .i_dv(dv_in[2]), .o_ready(c_rdy),
    .o_data(c_od), .o_dv(c_dv), .i_ready(rdy_in[2]), .i_cnt_clr(clr_in[2]), .o_count(c_cnt));
  hamming_stream_encoder #(.M(4), .K(8), .SECDED(0), .PIPE_STAGES(2), .CNT_W(16)) u_d (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_data(din[3][7:0]), .i_dv(dv_in[3]), .o_ready(d_rdy),
    .o_data(d_od), .o_dv(d_dv), .i_ready(rdy_in[3]), .i_cnt_clr(clr_in[3]), .o_count(d_cnt));

  logic [15:0] dout[4];
  logic [15:0] cnt[4];
  logic        dvo[4];
  logic        rdo[4];

  always_comb begin
    dout[0] = {8'h00, a_od}; dout[1] = {9'h000, b_od}; dout[2] = c_od; dout[3] = {4'h0, d_od};
    cnt[0]  = {12'h000, a_cnt}; cnt[1] = b_cnt; cnt[2] = c_cnt; cnt[3] = d_cnt;
    dvo[0]  = a_dv;  dvo[1] = b_dv;  dvo[2] = c_dv;  dvo[3] = d_dv;
    rdo[0]  = a_rdy; rdo[1] = b_rdy; rdo[2] = c_rdy; rdo[3] = d_rdy;
  end

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] fifo[4][64];
  int          head[4];
  int          tail[4];
  int          cnt_m[4];
  logic        prev_stall[4];
  logic [15:0] prev_dat[4];
  logic        acc[4];
  logic        nr_seen[4];

  logic [3:0] vv[4];
  logic [7:0] ea[4];
  logic [6:0] eb[4];

  task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, got, exp);
    end
  endtask

  // Position of data bit idx inside the Hamming codeword (positions 1..2^m-1).
  function automatic int dpos(input int m, input int idx);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int p = 1; p < (1 << m); p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) r = p;
        n++;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_code(input int i, input logic [15:0] d);
    logic [15:0] c;
    logic        x;
    int          m;
    int          k;
    m = PM[i];
    k = PK[i];
    c = '0;
    for (int b = 0; b < k; b++) c[b] = d[b];
    for (int j = 0; j < m; j++) begin
      x = 1'b0;
      for (int b = 0; b < k; b++) if (((dpos(m, b) >> j) & 1) == 1) x = x ^ d[b];
      c[k + j] = x;
    end
    if (PS[i] == 1) c[k + m] = ^c;
    return c;
  endfunction

  function automatic int syndrome(input int i, input logic [15:0] w);
    int s;
    s = 0;
    for (int b = 0; b < PK[i]; b++) if (w[b]) s = s ^ dpos(PM[i], b);
    for (int j = 0; j < PM[i]; j++) if (w[PK[i] + j]) s = s ^ (1 << j);
    return s;
  endfunction

  function automatic logic overall(input int i, input logic [15:0] w);
    logic x;
    x = 1'b0;
    for (int b = 0; b <= PK[i] + PM[i]; b++) x = x ^ w[b];
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0; tail[i] = 0; cnt_m[i] = 0; prev_stall[i] = 1'b0;
    end
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic cycle();
    int          occ;
    logic [15:0] exp_w;
    for (int i = 0; i < 4; i++) check("count", i, 32'(cnt[i]), 32'(cnt_m[i]));
    #1;
    for (int i = 0; i < 4; i++) begin
      occ = tail[i] - head[i];
      check("o_ready", i, 32'(rdo[i]), 32'((occ < PP[i]) || rdy_in[i]));
      if (!rdo[i]) nr_seen[i] = 1'b1;
      if (occ == 0) check("idle_dv", i, 32'(dvo[i]), 32'd0);
      if (prev_stall[i]) begin
        check("hold_dv", i, 32'(dvo[i]), 32'd1);
        check("hold_data", i, 32'(dout[i]), 32'(prev_dat[i]));
      end
      if (dvo[i] && rdy_in[i] && occ > 0) begin
        exp_w = fifo[i][head[i] % 64];
        head[i]++;
        check("codeword", i, 32'(dout[i]), 32'(exp_w));
        check("syndrome", i, 32'(syndrome(i, dout[i])), 32'd0);
        if (PS[i] == 1) check("even_par", i, 32'(overall(i, dout[i])), 32'd0);
      end
      prev_stall[i] = dvo[i] && !rdy_in[i];
      prev_dat[i]   = dout[i];
      acc[i] = dv_in[i] && rdo[i];
      if (acc[i]) begin
        fifo[i][tail[i] % 64] = ref_code(i, din[i] & 16'((1 << PK[i]) - 1));
        tail[i]++;
      end
      if (clr_in[i])                 cnt_m[i] = 0;
      else if (dvo[i] && rdy_in[i])  cnt_m[i] = (cnt_m[i] + 1) & ((1 << PCW[i]) - 1);
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive_all(input logic [15:0] d, input logic dv, input logic rdy, input logic clr);
    for (int i = 0; i < 4; i++) begin
      din[i] = d; dv_in[i] = dv; rdy_in[i] = rdy; clr_in[i] = clr;
    end
  endtask

  initial begin
    int          idx[4];
    int          t;
    logic        busy;
    logic [15:0] x;

    vv = '{4'b1011, 4'b0001, 4'b1111, 4'b0000};
    ea = '{8'h1B, 8'hB1, 8'hFF, 8'h00};
    eb = '{7'h1B, 7'h31, 7'h7F, 7'h00};
    for (int i = 0; i < 4; i++) nr_seen[i] = 1'b0;
    rst_n = 1'b0;
    drive_all(16'h0000, 1'b0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_dv", i, 32'(dvo[i]), 32'd0);
      check("rst_data", i, 32'(dout[i]), 32'd0);
      check("rst_count", i, 32'(cnt[i]), 32'd0);
    end
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) check("ready_after_rst", i, 32'(rdo[i]), 32'd1);

    // Directed vectors with known codewords, plus 2-stage latency.
    for (int v = 0; v < 4; v++) begin
      x = {12'h000, vv[v]};
      drive_all(x, 1'b1, 1'b1, 1'b0);
      cycle();
      check("vec_dv", 0, 32'(dvo[0]), 32'd1);
      check("vec_secded", 0, 32'(dout[0]), 32'(ea[v]));
      check("vec_dv", 1, 32'(dvo[1]), 32'd1);
      check("vec_plain", 1, 32'(dout[1]), 32'(eb[v]));
      if (v == 0) check("lat2_empty", 2, 32'(dvo[2]), 32'd0);
      if (v == 1) check("lat2_word", 2, 32'(dout[2]), 32'(ref_code(2, 16'h000B)));
    end
    drive_all(16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle();

    // Randomised traffic with random backpressure and occasional counter clears.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        din[i]    = 16'($urandom);
        dv_in[i]  = $urandom_range(0, 3) != 0;
        rdy_in[i] = $urandom_range(0, 3) != 0;
        clr_in[i] = $urandom_range(0, 31) == 0;
      end
      cycle();
    end
    drive_all(16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle();
    drive_all(16'h0000, 1'b0, 1'b1, 1'b1);
    cycle();

    // Stream 0..9 under a 1,0,0 ready pattern.
    for (int i = 0; i < 4; i++) begin idx[i] = 0; nr_seen[i] = 1'b0; end
    t = 0;
    busy = 1'b1;
    while (busy && t < 200) begin
      for (int i = 0; i < 4; i++) begin
        din[i] = 16'(idx[i]); dv_in[i] = idx[i] < 10; rdy_in[i] = (t % 3) == 0; clr_in[i] = 1'b0;
      end
      cycle();
      busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) idx[i]++;
        if (idx[i] < 10 || tail[i] != head[i]) busy = 1'b1;
      end
      t++;
    end
    for (int i = 0; i < 4; i++) begin
      check("bp_sent", i, 32'(idx[i]), 32'd10);
      check("bp_count", i, 32'(cnt[i]), 32'd10);
    end
    check("bp_ready_drop", 2, 32'(nr_seen[2]), 32'd1);
    check("bp_ready_drop", 3, 32'(nr_seen[3]), 32'd1);

    // Counter wrap at CNT_W=4 and clear-wins-over-transfer.
    drive_all(16'h0000, 1'b0, 1'b1, 1'b1);
    cycle();
    for (int n = 0; n < 17; n++) begin
      drive_all(16'($urandom), 1'b1, 1'b1, 1'b0);
      cycle();
    end
    drive_all(16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle();
    check("wrap_count", 0, 32'(cnt[0]), 32'd1);
    check("wrap_count", 1, 32'(cnt[1]), 32'd17);
    drive_all(16'h0005, 1'b1, 1'b1, 1'b0);
    cycle();
    check("clr_dv", 0, 32'(dvo[0]), 32'd1);
    drive_all(16'h0000, 1'b0, 1'b1, 1'b1);
    cycle();
    check("clr_count", 0, 32'(cnt[0]), 32'd0);
    drive_all(16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle();

    // Asynchronous reset with words in flight.
    drive_all(16'($urandom), 1'b1, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("async_dv", i, 32'(dvo[i]), 32'd0);
      check("async_count", i, 32'(cnt[i]), 32'd0);
    end
    model_reset();
    @(negedge i_clk);
    rst_n = 1'b1;
    x = 16'($urandom);
    drive_all(x, 1'b1, 1'b1, 1'b0);
    cycle();
    drive_all(16'h0000, 1'b0, 1'b1, 1'b0);
    check("post_rst_word", 0, 32'(dout[0]), 32'(ref_code(0, x & 16'h000F)));
    check("post_rst_lat", 2, 32'(dvo[2]), 32'd0);
    cycle();
    check("post_rst_dv", 2, 32'(dvo[2]), 32'd1);
    check("post_rst_word", 3, 32'(dout[3]), 32'(ref_code(3, x & 16'h00FF)));
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) check("drained", i, 32'(tail[i] - head[i]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
